teclado_config: RTL and testbench
=================================

# teclado_config

Keypad front end for the stopwatch/timer counter. Scans a 4x4 active-low matrix keypad, debounces presses, and turns each accepted key into the counter's control inputs: `cfg` mode, `salve` strobe, `sel`, `pause`, the toggle-style `reseta`, and the binary `tempo` limit entered as four decimal digits. It drives the counter's `tempo`/`cfg`/`salve`/`sel`/`pause`/`reseta` inputs directly.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each row is driven (dwell); must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-frame results needed to accept a press or a release; must be ≥ 1.
- `clk` in 1: system clock, 50 MHz in the board build.
- `reseta_n` in 1: asynchronous, active-low reset.
- `linhas` out 4: row drives, active-low, exactly one bit low at a time.
- `colunas` in 4: column sense, active-low (pulled up), asynchronous to `clk`.
- `tempo` out 16: binary value of the entered digits, 0..9999.
- `digitos` out 16: entered digits, BCD {D3,D2,D1,D0}, for display.
- `cfg` out 1: 1 = configuration mode, 0 = run mode.
- `salve` out 1: one-cycle strobe on `#`.
- `sel` out 1: 0 = stopwatch, 1 = timer.
- `pause` out 1: level; 1 = display frozen.
- `reseta` out 1: level that toggles once per reset request; the counter resets on each change.

## Operation
- Key map (row, col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D. Column index 0 is `colunas[0]`.
- Scan: row index advances 0→1→2→3→0 every `SCAN_DIV` cycles. `linhas` = ~(1 << row).
- `colunas` passes through a 2-FF synchronizer. It is sampled on the last cycle of each dwell.
- A frame is 4 dwells. Frame result:
  - NONE: no low column in any row.
  - KEY(code): exactly one low column in exactly one row.
  - MULTI: anything else.
- Debounce FSM, evaluated once per frame end:
  - IDLE: KEY(c) → CONFIRM, with cand = c and cnt = 1.
  - CONFIRM: KEY(cand) → cnt+1. When cnt reaches `DEBOUNCE_SCANS`, emit a one-cycle event(cand) and go to HELD. Any other result → IDLE.
  - HELD: NONE → RELEASE with cnt = 1. KEY/MULTI → stay.
  - RELEASE: NONE → cnt+1. When cnt reaches `DEBOUNCE_SCANS`, go to IDLE. KEY/MULTI → HELD.
  - MULTI never produces an event. Holding a key gives one event only; no auto-repeat.
  - With `DEBOUNCE_SCANS` = 1, the event fires at the end of the first KEY frame (IDLE→HELD directly), and release completes at the first NONE frame.
- Event actions:
  - `*`: toggle `cfg`. On a 0→1 transition, also clear `digitos` to 0.
  - `0`–`9`, only when `cfg` = 1: `digitos` <= {D2,D1,D0,key}. The old D3 is discarded. Ignored when `cfg` = 0.
  - `#`: `salve` = 1 for one cycle in either mode. No other state changes.
  - `A` / `B`, only when `cfg` = 1: `sel` <= 0 / 1.
  - `C`, only when `cfg` = 0: toggle `pause`.
  - `D`, only when `cfg` = 0: toggle `reseta`. Also clear `pause`.
  - Keys ignored in the current mode have no effect. They are still debounced and consume the press.
- `tempo` = D3·1000 + D2·100 + D1·10 + D0. It is computed from `digitos` and registered. It tracks `digitos` in both modes.

## Timing
- Reset values: `linhas` = 4'b1110, row index 0, synchronizer FFs = 4'b1111, FSM IDLE, `digitos` = 0, `tempo` = 0, `cfg` = 1, `salve` = 0, `sel` = 0, `pause` = 0, `reseta` = 0.
- Asserting reset mid-scan or mid-debounce returns to these values immediately. No event is emitted for a key held through reset release until it passes a full debounce from IDLE.
- Event latency: the event is registered on the cycle after the last dwell sample of the `DEBOUNCE_SCANS`-th consecutive KEY frame.
- All outputs update on the cycle after the event. `tempo` updates one cycle after `digitos`.
- `salve` is high for exactly 1 cycle per `#` press.
- At most one event per press/release cycle. The minimum spacing between events is 2·`DEBOUNCE_SCANS` frames.

## Test plan
Bench parameters: `SCAN_DIV` = 4, `DEBOUNCE_SCANS` = 2, so one frame = 16 cycles.
- Reset, idle columns high → `linhas` cycles 1110, 1101, 1011, 0111 every 4 cycles; `cfg` = 1, `tempo` = 0, no `salve`.
- In config, press and release `1`, `2`, `3`, `4`, `5`, each held for 3 frames → `digitos` = 16'h2345, `tempo` = 2345. Then `B` → `sel` = 1.
- `#` held for 10 frames → exactly one `salve` pulse of 1 cycle. A 1-frame glitch on `7` → no event, `digitos` unchanged.
- `*` → `cfg` = 0. Then digit `9` → ignored. `C` → `pause` = 1. `D` → `reseta` = 1 and `pause` = 0. `D` again → `reseta` = 0.
- `*` and `5` held simultaneously → MULTI, no events. `*` from run mode → `cfg` = 1 and `digitos` = 0.
- Assert `reseta_n` while `8` is in CONFIRM → all outputs return to reset values. After release with `8` still held, an event occurs only after 2 further KEY frames.

Source files
------------

// File: rtl/teclado_config.sv
// Keypad front end: scans a 4x4 active-low matrix, debounces whole scan frames
// and maps each accepted key onto the stopwatch/timer control inputs.
//
// state      | meaning
// ST_IDLE    | nothing accepted, waiting for a single-key frame
// ST_CONFIRM | candidate key seen in cnt consecutive frames
// ST_HELD    | event emitted, waiting for the keypad to go quiet
// ST_RELEASE | empty frames seen cnt times in a row
module teclado_config #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reseta_n,
    output logic [3:0]  linhas,
    input  logic [3:0]  colunas,
    output logic [15:0] tempo,
    output logic [15:0] digitos,
    output logic        cfg,
    output logic        salve,
    output logic        sel,
    output logic        pause,
    output logic        reseta
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(SCAN_DIV - 1);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DEB_N = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD, ST_RELEASE} state_t;

    logic [DW-1:0] dwell_cnt;
    logic [1:0]    row;
    logic [3:0]    col_s1, col_s2;
    logic          dwell_end, frame_end;

    res_t          acc_res, nxt_res;
    logic [3:0]    acc_code, nxt_code;
    logic          row_none, row_one;
    logic [1:0]    row_col;

    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic          event_valid;
    logic [3:0]    event_code;

    logic          is_digit;
    logic [3:0]    digit;
    logic [15:0]   tempo_nxt;

    assign dwell_end = (dwell_cnt == '0);
    assign frame_end = dwell_end && (row == 2'd3);

    // Row drive, dwell timer and column synchronizer
    always_ff @(posedge clk or negedge reseta_n) begin
        if (!reseta_n) begin
            dwell_cnt <= DWELL_LOAD;
            row       <= 2'd0;
            linhas    <= 4'b1110;
            col_s1    <= 4'b1111;
            col_s2    <= 4'b1111;
        end else begin
            col_s1 <= colunas;
            col_s2 <= col_s1;
            if (dwell_end) begin
                dwell_cnt <= DWELL_LOAD;
                row       <= row + 2'd1;
                linhas    <= {linhas[2:0], linhas[3]};
            end else begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        row_none = (col_s2 == 4'b1111);
        row_one  = 1'b1;
        row_col  = 2'd0;
        case (col_s2)
            4'b1110: row_col = 2'd0;
            4'b1101: row_col = 2'd1;
            4'b1011: row_col = 2'd2;
            4'b0111: row_col = 2'd3;
            default: row_one = 1'b0;
        endcase
    end

    // Result of the frame so far, including the row being sampled now
    always_comb begin
        nxt_res  = acc_res;
        nxt_code = acc_code;
        if (!row_none) begin
            if (row_one && acc_res == RES_NONE) begin
                nxt_res  = RES_KEY;
                nxt_code = {row, row_col};
            end else begin
                nxt_res = RES_MULTI;
            end
        end
    end

    always_ff @(posedge clk or negedge reseta_n) begin
        if (!reseta_n) begin
            acc_res  <= RES_NONE;
            acc_code <= 4'd0;
        end else if (dwell_end) begin
            if (row == 2'd3) begin
                acc_res  <= RES_NONE;
                acc_code <= 4'd0;
            end else begin
                acc_res  <= nxt_res;
                acc_code <= nxt_code;
            end
        end
    end

    always_ff @(posedge clk or negedge reseta_n) begin
        if (!reseta_n) begin
            state       <= ST_IDLE;
            cand        <= 4'd0;
            cnt         <= '0;
            event_valid <= 1'b0;
            event_code  <= 4'd0;
        end else begin
            event_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    ST_IDLE: begin
                        if (nxt_res == RES_KEY) begin
                            cand <= nxt_code;
                            cnt  <= CNT_ONE;
                            if (DEB_N == CNT_ONE) begin
                                event_valid <= 1'b1;
                                event_code  <= nxt_code;
                                state       <= ST_HELD;
                            end else begin
                                state <= ST_CONFIRM;
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if (nxt_res == RES_KEY && nxt_code == cand) begin
                            cnt <= cnt + CNT_ONE;
                            if (cnt + CNT_ONE == DEB_N) begin
                                event_valid <= 1'b1;
                                event_code  <= cand;
                                state       <= ST_HELD;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (nxt_res == RES_NONE) begin
                            cnt   <= CNT_ONE;
                            state <= (DEB_N == CNT_ONE) ? ST_IDLE : ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (nxt_res == RES_NONE) begin
                            cnt <= cnt + CNT_ONE;
                            if (cnt + CNT_ONE == DEB_N) state <= ST_IDLE;
                        end else begin
                            state <= ST_HELD;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (event_code)
            4'd0:    digit = 4'd1;
            4'd1:    digit = 4'd2;
            4'd2:    digit = 4'd3;
            4'd4:    digit = 4'd4;
            4'd5:    digit = 4'd5;
            4'd6:    digit = 4'd6;
            4'd8:    digit = 4'd7;
            4'd9:    digit = 4'd8;
            4'd10:   digit = 4'd9;
            4'd13:   digit = 4'd0;
            default: is_digit = 1'b0;
        endcase
    end

    assign tempo_nxt = 16'(digitos[15:12]) * 16'd1000 + 16'(digitos[11:8]) * 16'd100
                     + 16'(digitos[7:4]) * 16'd10 + 16'(digitos[3:0]);

    always_ff @(posedge clk or negedge reseta_n) begin
        if (!reseta_n) begin
            digitos <= 16'd0;
            tempo   <= 16'd0;
            cfg     <= 1'b1;
            salve   <= 1'b0;
            sel     <= 1'b0;
            pause   <= 1'b0;
            reseta  <= 1'b0;
        end else begin
            salve <= 1'b0;
            tempo <= tempo_nxt;
            if (event_valid) begin
                if (is_digit) begin
                    if (cfg) digitos <= {digitos[11:0], digit};
                end else begin
                    case (event_code)
                        KEY_STAR: begin
                            cfg <= ~cfg;
                            if (!cfg) digitos <= 16'd0;
                        end
                        KEY_HASH: salve <= 1'b1;
                        KEY_A:    if (cfg) sel <= 1'b0;
                        KEY_B:    if (cfg) sel <= 1'b1;
                        KEY_C:    if (!cfg) pause <= ~pause;
                        KEY_D: begin
                            if (!cfg) begin
                                reseta <= ~reseta;
                                pause  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_teclado_config.sv
// Bench for teclado_config: frame-level keypad model plus directed key sequences
// with hand-computed checkpoints.
module tb_teclado_config;

    localparam int SD  = 4;
    localparam int DEB = 2;
    localparam int FR  = 4 * SD;

    logic        clk = 1'b0;
    logic        reseta_n = 1'b0;
    logic [3:0]  linhas;
    logic [3:0]  colunas;
    logic [15:0] tempo, digitos;
    logic        cfg, salve, sel, pause, reseta;

    logic [15:0] keys = 16'd0;
    string       keymap = "123A456B789C*0#D";

    int total = 0;
    int bad = 0;

    teclado_config #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .reseta_n(reseta_n), .linhas(linhas), .colunas(colunas),
        .tempo(tempo), .digitos(digitos), .cfg(cfg), .salve(salve),
        .sel(sel), .pause(pause), .reseta(reseta)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row line onto its column line
    always_comb begin
        colunas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!linhas[r] && keys[r*4+c]) colunas[c] = 1'b0;
    end

    // Model state: what the outputs must be, derived frame by frame
    int          p = 0;
    logic [15:0] m_dig = 16'd0;
    logic [15:0] m_tempo = 16'd0;
    logic        m_cfg = 1'b1, m_salve = 1'b0, m_sel = 1'b0, m_pause = 1'b0, m_reseta = 1'b0;
    logic [3:0]  m_lin = 4'b1110;
    logic        armed = 1'b1;
    int          run_code = 0, run_len = 0, none_len = 0;
    logic        ev_pending = 1'b0;
    int          ev_code = 0;

    function automatic int bcd_value(input logic [15:0] d);
        return int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [15:0] key_mask(input byte ch);
        logic [15:0] m;
        m = 16'd0;
        for (int i = 0; i < 16; i++)
            if (keymap[i] == ch) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        p = 0; m_dig = 16'd0; m_tempo = 16'd0; m_cfg = 1'b1; m_salve = 1'b0;
        m_sel = 1'b0; m_pause = 1'b0; m_reseta = 1'b0; m_lin = 4'b1110;
        armed = 1'b1; run_code = 0; run_len = 0; none_len = 0; ev_pending = 1'b0;
    endtask

    task automatic model_apply(input int code);
        byte ch;
        ch = keymap[code];
        if (ch >= "0" && ch <= "9") begin
            if (m_cfg) m_dig = {m_dig[11:0], 4'(ch - 8'd48)};
        end else if (ch == "*") begin
            if (!m_cfg) m_dig = 16'd0;
            m_cfg = ~m_cfg;
        end else if (ch == "#") m_salve = 1'b1;
        else if (ch == "A" && m_cfg) m_sel = 1'b0;
        else if (ch == "B" && m_cfg) m_sel = 1'b1;
        else if (ch == "C" && !m_cfg) m_pause = ~m_pause;
        else if (ch == "D" && !m_cfg) begin
            m_reseta = ~m_reseta;
            m_pause = 1'b0;
        end
    endtask

    // Keys are only changed at frame boundaries, so one frame sees one key set
    task automatic model_frame();
        int n, c;
        n = $countones(keys);
        c = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) c = i;
        if (armed) begin
            if (n == 1) begin
                if (run_len == 0) begin run_code = c; run_len = 1; end
                else if (c == run_code) run_len++;
                else run_len = 0;
                if (run_len == DEB) begin
                    ev_pending = 1'b1; ev_code = c;
                    armed = 1'b0; none_len = 0; run_len = 0;
                end
            end else run_len = 0;
        end else begin
            if (n == 0) begin
                none_len++;
                if (none_len == DEB) armed = 1'b1;
            end else none_len = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reseta_n);
            if (!reseta_n) model_reset();
            else begin
                p++;
                m_tempo = 16'(bcd_value(m_dig));
                m_salve = 1'b0;
                if (ev_pending) begin
                    model_apply(ev_code);
                    ev_pending = 1'b0;
                end
                if (p % FR == 0) model_frame();
                m_lin = ~(4'b0001 << ((p / SD) % 4));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            total++;
            if ({linhas, digitos, tempo, cfg, salve, sel, pause, reseta} !==
                {m_lin, m_dig, m_tempo, m_cfg, m_salve, m_sel, m_pause, m_reseta}) begin
                bad++;
                $display("FAIL outputs t=%0t got lin=%b dig=%h tempo=%0d cfg=%b salve=%b sel=%b pause=%b reseta=%b want lin=%b dig=%h tempo=%0d cfg=%b salve=%b sel=%b pause=%b reseta=%b",
                         $time, linhas, digitos, tempo, cfg, salve, sel, pause, reseta,
                         m_lin, m_dig, m_tempo, m_cfg, m_salve, m_sel, m_pause, m_reseta);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold_keys(input logic [15:0] mask, input int hold, input int rel, output int pulses);
        pulses = 0;
        keys = mask;
        repeat (hold * FR) begin
            @(negedge clk);
            if (salve) pulses++;
        end
        keys = 16'd0;
        repeat (rel * FR) begin
            @(negedge clk);
            if (salve) pulses++;
        end
    endtask

    task automatic press(input byte ch, input int hold, input int rel);
        int pulses;
        hold_keys(key_mask(ch), hold, rel, pulses);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [3:0] lin_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int pulses;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_linhas", int'(linhas), 4'b1110);
        check("reset_cfg", int'(cfg), 1);
        check("reset_tempo", int'(tempo), 0);
        check("reset_salve", int'(salve), 0);
        #2 reseta_n = 1'b1;

        for (int i = 0; i < FR; i++) begin
            check("scan_linhas", int'(linhas), int'(lin_tab[i / SD]));
            @(negedge clk);
        end

        press("1", 3, 3);
        press("2", 3, 3);
        press("3", 3, 3);
        press("4", 3, 3);
        press("5", 3, 3);
        check("entry_digitos", int'(digitos), 16'h2345);
        check("entry_tempo", int'(tempo), 2345);
        press("B", 3, 3);
        check("sel_timer", int'(sel), 1);

        hold_keys(key_mask("#"), 10, 3, pulses);
        check("salve_pulses", pulses, 1);
        press("7", 1, 3);
        check("glitch_digitos", int'(digitos), 16'h2345);

        press("*", 3, 3);
        check("run_cfg", int'(cfg), 0);
        press("9", 3, 3);
        check("run_digit_ignored", int'(digitos), 16'h2345);
        press("C", 3, 3);
        check("pause_on", int'(pause), 1);
        press("D", 3, 3);
        check("reseta_toggle1", int'(reseta), 1);
        check("pause_cleared", int'(pause), 0);
        press("D", 3, 3);
        check("reseta_toggle2", int'(reseta), 0);

        hold_keys(key_mask("*") | key_mask("5"), 3, 3, pulses);
        check("multi_cfg", int'(cfg), 0);
        check("multi_digitos", int'(digitos), 16'h2345);
        press("*", 3, 3);
        check("back_cfg", int'(cfg), 1);
        check("back_digitos", int'(digitos), 0);

        keys = key_mask("8");
        repeat (FR + 5) @(negedge clk);
        #2 reseta_n = 1'b0;
        @(negedge clk);
        check("rst_linhas", int'(linhas), 4'b1110);
        check("rst_sel", int'(sel), 0);
        check("rst_cfg", int'(cfg), 1);
        check("rst_digitos", int'(digitos), 0);
        repeat (2) @(negedge clk);
        #2 reseta_n = 1'b1;
        repeat (2 * FR) @(negedge clk);
        check("rst_no_early_event", int'(digitos), 0);
        @(negedge clk);
        check("rst_event_digitos", int'(digitos), 16'h0008);
        @(negedge clk);
        check("rst_event_tempo", int'(tempo), 8);
        keys = 16'd0;
        repeat (3 * FR) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
